// File: rtl/ascii_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_uart_tx
//  Description : Buffers ASCII characters from the inference engine in a
//                small FIFO and serialises them as 8N1 UART frames. When
//                generation ends, it sends CR LF after everything already
//                queued, then pulses line_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        gen_complete,
    output logic        uart_txd,
    output logic        busy,
    output logic [11:0] sent_count,
    output logic        line_done
);

    localparam int             c_aw        = $clog2(DEPTH);
    localparam logic [15:0]    c_baud_last = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]     c_cr        = 8'h0D;
    localparam logic [7:0]     c_lf        = 8'h0A;
    localparam logic [c_aw:0]  c_ptr_one   = (c_aw + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state, w_next_state;

    logic [7:0]    r_mem [DEPTH];
    logic [c_aw:0] r_wr_ptr, r_rd_ptr;
    logic          w_full, w_empty, w_push, w_pop;

    logic          r_ready_en;
    logic          r_eol_pending, r_eol_idx;
    logic          r_is_fifo, r_is_lf;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd, r_line_done;
    logic [11:0]   r_sent_count;

    logic          w_bit_end, w_load, w_load_fifo, w_load_lf, w_frame_end, w_txd;
    logic [7:0]    w_load_val;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    // r_ready_en keeps char_ready low while reset is asserted.
    assign char_ready = r_ready_en && !w_full && !r_eol_pending;
    assign w_push     = char_valid && char_ready;
    assign w_bit_end  = (r_baud == c_baud_last);

    assign uart_txd   = r_txd;
    assign busy       = !w_empty || (r_state != S_IDLE) || r_eol_pending;
    assign sent_count = r_sent_count;
    assign line_done  = r_line_done;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= char_data;
        end
    end

    // FIFO pointers, ready gate and end-of-line request flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ready_en    <= 1'b0;
            r_eol_pending <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (w_frame_end && r_is_lf) begin
                r_eol_pending <= 1'b0;
            end else if (gen_complete) begin
                r_eol_pending <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state, frame-load decisions and the line level for each state.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_load_fifo  = 1'b0;
        w_load_lf    = 1'b0;
        w_load_val   = c_cr;
        w_frame_end  = 1'b0;
        w_txd        = 1'b1;
        case (r_state)
            S_IDLE: begin
                // Queued characters always go before the CR LF terminator.
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_load_fifo  = 1'b1;
                    w_load_val   = r_mem[r_rd_ptr[c_aw-1:0]];
                    w_next_state = S_START;
                end else if (r_eol_pending) begin
                    w_load       = 1'b1;
                    w_load_lf    = r_eol_idx;
                    w_load_val   = r_eol_idx ? c_lf : c_cr;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_end) w_next_state = S_DATA;
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_end && (r_bit == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                w_txd = 1'b1;
                if (w_bit_end) begin
                    w_frame_end  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Baud/bit timing, shift register, registered TX line and frame accounting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_is_fifo    <= 1'b0;
            r_is_lf      <= 1'b0;
            r_eol_idx    <= 1'b0;
            r_txd        <= 1'b1;
            r_line_done  <= 1'b0;
            r_sent_count <= '0;
        end else begin
            r_txd       <= w_txd;
            r_line_done <= 1'b0;
            if (w_load) begin
                r_shift   <= w_load_val;
                r_is_fifo <= w_load_fifo;
                r_is_lf   <= w_load_lf;
                r_baud    <= '0;
                r_bit     <= '0;
                if (!w_load_fifo && !r_eol_idx) r_eol_idx <= 1'b1;
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_baud <= '0;
                    if (r_state == S_DATA) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end
            if (w_frame_end) begin
                // Only payload characters count; the terminator does not.
                if (r_is_fifo && (r_sent_count != 12'hFFF)) begin
                    r_sent_count <= r_sent_count + 12'd1;
                end
                if (r_is_lf) begin
                    r_line_done <= 1'b1;
                    r_eol_idx   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
